// File: rtl/fsm_pkg.sv
// State encoding and decode constant for the 1-1-0 serial sequence detector.
package fsm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GOT1   = 2'b01,
        GOT11  = 2'b10,
        DETECT = 2'b11
    } state_t;

    localparam state_t DETECT_STATE = DETECT;

endpackage

// File: rtl/fsm.sv
// Moore detector: flags one cycle after the serial input shows 1-1-0, overlaps allowed.
// Latency: Out rises on the clock edge that samples the terminating 0.
// Backpressure: none; one bit is consumed every clock edge.
module fsm
    import fsm_pkg::*;
(
    output logic Out,
    input  logic reset_b,
    input  logic clock,
    input  logic In
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = In ? GOT1  : IDLE;
            GOT1:    state_d = In ? GOT11 : IDLE;
            GOT11:   state_d = In ? GOT11 : DETECT;
            // A 1 right after a detection already counts as the first bit of the next pattern.
            DETECT:  state_d = In ? GOT1  : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign Out = (state_q == DETECT_STATE);

    out_matches_state: assert property (@(posedge clock) disable iff (!reset_b)
        Out == (state_q == DETECT_STATE));

endmodule

// File: tb/tb_fsm.sv
// Bench for the 1-1-0 detector: history-based reference plus directed and random stimulus.
module tb_fsm;

    logic Out;
    logic reset_b;
    logic clock;
    logic In;

    int compared   = 0;
    int mismatched = 0;

    // Reference: the last three bits sampled since reset, oldest in the MSB.
    logic [2:0] hist;
    logic       exp_out;

    fsm dut (
        .Out     (Out),
        .reset_b (reset_b),
        .clock   (clock),
        .In      (In)
    );

    initial begin
        clock = 1'b0;
        #10 clock = 1'b1;
        forever #5 clock = ~clock;
    end

    always @(posedge clock or negedge reset_b) begin
        if (!reset_b) hist <= 3'b000;
        else          hist <= {hist[1:0], In};
    end

    assign exp_out = (reset_b === 1'b1) && (hist == 3'b110);

    always @(negedge clock) begin
        compared = compared + 1;
        if (Out !== exp_out) begin
            mismatched = mismatched + 1;
            $display("FAIL cycle_cmp t=%0t Out=%b expected %b hist=%b", $time, Out, exp_out, hist);
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp);
        end
    endtask

    // Drive a bit at posedge+2; returns at the following posedge+2 after it was sampled.
    task automatic send(input logic b);
        In = b;
        @(posedge clock);
        #2;
    endtask

    initial begin
        logic [4:0] nomatch;
        reset_b = 1'b0;
        In      = 1'b0;
        #3  check("reset_out", Out, 1'b0);
        #9  reset_b = 1'b1;
        #19 check("idle_after_zeros", (dut.state_q == fsm_pkg::IDLE), 1'b1);
        check("zeros_out", Out, 1'b0);
        #1  In = 1'b1;
        #20 In = 1'b0;
        #5  check("basic_before", Out, 1'b0);
        #8  check("basic_hi", Out, 1'b1);
        #10 check("basic_after", Out, 1'b0);
        #427;

        send(1'b1); send(1'b1); send(1'b0);
        check("ovl_a", Out, 1'b1);
        send(1'b1);
        check("ovl_a_drop", Out, 1'b0);
        send(1'b1); send(1'b0);
        check("ovl_b", Out, 1'b1);

        send(1'b0);
        for (int i = 0; i < 5; i++) begin
            send(1'b1);
            check("ones_run", Out, 1'b0);
        end
        send(1'b0);
        check("ones_then_zero", Out, 1'b1);
        send(1'b0);
        check("ones_then_zero_drop", Out, 1'b0);

        nomatch = 5'b10100;
        for (int i = 4; i >= 0; i--) begin
            send(nomatch[i]);
            check("nonmatch", Out, 1'b0);
        end

        send(1'b1); send(1'b1); send(1'b0);
        check("pre_reset_hi", Out, 1'b1);
        #1 reset_b = 1'b0;
        #1 check("async_rst", Out, 1'b0);
        @(posedge clock);
        #2 check("held_in_reset", Out, 1'b0);
        reset_b = 1'b1;
        send(1'b0);
        check("post_rst_0", Out, 1'b0);
        send(1'b1);
        check("post_rst_1", Out, 1'b0);
        send(1'b1);
        check("post_rst_11", Out, 1'b0);
        send(1'b0);
        check("post_rst_110", Out, 1'b1);

        for (int i = 0; i < 400; i++) begin
            send(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0);
            if ($urandom_range(0, 29) == 0) begin
                #1 reset_b = 1'b0;
                #1 check("rand_async_rst", Out, 1'b0);
                @(posedge clock);
                #2 reset_b = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
